leaky_relu_backward: RTL and testbench



---
 rtl/leaky_relu_backward.sv | 128 ++++++++++++
 tb/tb_leaky_relu_backward.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/leaky_relu_backward.sv
// Leaky ReLU backward pass: joins queued forward sign masks with gradient beats,
// scales negative lanes by a fixed-point slope and saturates into a registered output.
`timescale 1ns/1ps
module leaky_relu_backward #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int SLOPE_FRAC_WIDTH            = 8,
  parameter int NEGATIVE_SLOPE              = 26,
  parameter int MASK_FIFO_DEPTH             = 8,
  localparam int P  = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
  localparam int IW = DATA_IN_0_PRECISION_0,
  localparam int OW = DATA_OUT_0_PRECISION_0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [P-1:0]    mask_in_0,
  input  logic            mask_in_0_valid,
  output logic            mask_in_0_ready,
  input  logic [P*IW-1:0] data_in_0,
  input  logic            data_in_0_valid,
  output logic            data_in_0_ready,
  output logic [P*OW-1:0] data_out_0,
  output logic            data_out_0_valid,
  input  logic            data_out_0_ready
);

  localparam int SF    = SLOPE_FRAC_WIDTH;
  localparam int SHIFT = DATA_OUT_0_PRECISION_1 - DATA_IN_0_PRECISION_1;
  localparam int SHL   = (SHIFT > 0) ? SHIFT : 0;
  localparam int SHR   = (SHIFT < 0) ? -SHIFT : 0;
  localparam int PW    = IW + SF + 1;
  // Aligned width leaves headroom for the left shift and at least one guard bit above OW.
  localparam int AW    = (PW + SHL + 1 > OW + 1) ? PW + SHL + 1 : OW + 1;
  localparam int PTRW  = $clog2(MASK_FIFO_DEPTH);
  localparam int CW    = $clog2(MASK_FIFO_DEPTH + 1);

  localparam logic [CW-1:0]        DEPTH_C   = CW'(MASK_FIFO_DEPTH);
  localparam logic signed [PW-1:0] SLOPE_EXT = PW'(NEGATIVE_SLOPE);
  localparam logic signed [AW-1:0] OUT_MAX   = AW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] OUT_MIN   = -OUT_MAX - AW'(1);

  logic [P-1:0]    mask_mem [MASK_FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [P*OW-1:0] data_out_q, data_out_d, dx;
  logic            push, pop, stage_ready;
  logic [P-1:0]    head_mask;

  function automatic logic [OW-1:0] lane_dx(input logic signed [IW-1:0] dy, input logic neg);
    logic signed [PW-1:0] dy_ext, prod, s;
    logic signed [AW-1:0] aligned;
    logic [OW-1:0]        res;
    dy_ext = PW'(dy);
    prod   = dy_ext * SLOPE_EXT;
    s      = neg ? (prod >>> SF) : dy_ext;
    aligned = AW'(s);
    if (SHIFT >= 0) aligned = aligned <<< SHL;
    else            aligned = aligned >>> SHR;
    if (aligned > OUT_MAX)      res = OUT_MAX[OW-1:0];
    else if (aligned < OUT_MIN) res = OUT_MIN[OW-1:0];
    else                        res = aligned[OW-1:0];
    return res;
  endfunction

  assign head_mask        = mask_mem[rd_ptr_q];
  assign stage_ready      = !out_valid_q || data_out_0_ready;
  assign mask_in_0_ready  = !rst && (count_q < DEPTH_C);
  assign data_in_0_ready  = !rst && (count_q != '0) && stage_ready;
  assign push             = mask_in_0_valid && mask_in_0_ready;
  assign pop              = data_in_0_valid && data_in_0_ready;
  assign data_out_0       = data_out_q;
  assign data_out_0_valid = out_valid_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dx = '0;
    for (int i = 0; i < P; i++) begin
      dx[i*OW +: OW] = lane_dx(data_in_0[i*IW +: IW], head_mask[i]);
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      out_valid_d = 1'b1;
      data_out_d  = dx;
    end else if (data_out_0_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  // NOTE: mask storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mask_mem[wr_ptr_q] <= mask_in_0;
  end

endmodule

// File: tb/tb_leaky_relu_backward.sv
// Directed bench for leaky_relu_backward: default config plus a widened-fraction
// instance that exercises the left shift and saturation.
`timescale 1ns/1ps
module tb_leaky_relu_backward;

  localparam int P = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [P-1:0]   mask;
  logic           mask_valid, mask_ready;
  logic [P*W-1:0] din;
  logic           din_valid, din_ready;
  logic [P*W-1:0] dout;
  logic           dout_valid, dout_ready;

  logic [P-1:0]   s_mask;
  logic           s_mask_valid, s_mask_ready;
  logic [P*W-1:0] s_din;
  logic           s_din_valid, s_din_ready;
  logic [P*W-1:0] s_dout;
  logic           s_dout_valid, s_dout_ready;

  leaky_relu_backward dut (
    .clk(clk), .rst(rst),
    .mask_in_0(mask), .mask_in_0_valid(mask_valid), .mask_in_0_ready(mask_ready),
    .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(din_ready),
    .data_out_0(dout), .data_out_0_valid(dout_valid), .data_out_0_ready(dout_ready)
  );

  leaky_relu_backward #(.DATA_OUT_0_PRECISION_1(6)) dut_sat (
    .clk(clk), .rst(rst),
    .mask_in_0(s_mask), .mask_in_0_valid(s_mask_valid), .mask_in_0_ready(s_mask_ready),
    .data_in_0(s_din), .data_in_0_valid(s_din_valid), .data_in_0_ready(s_din_ready),
    .data_out_0(s_dout), .data_out_0_valid(s_dout_valid), .data_out_0_ready(s_dout_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane 0 is the least significant slice.
  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  logic [31:0] dy_a, dx_pass, dx_neg;

  // Expected output for dy_a under a mixed mask, built from the hand-computed lane values.
  function automatic logic [31:0] mix(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m[i] ? dx_neg[i*8 +: 8] : dx_pass[i*8 +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_mask(input logic [3:0] m);
    mask = m;
    mask_valid = 1'b1;
    step();
    mask_valid = 1'b0;
  endtask

  task automatic sat_beat(input string tag, input logic [3:0] m, input logic [31:0] d,
                          input logic [31:0] exp);
    s_mask = m;
    s_mask_valid = 1'b1;
    step();
    s_mask_valid = 1'b0;
    s_din = d;
    s_din_valid = 1'b1;
    step();
    s_din_valid = 1'b0;
    check({tag, " valid"}, s_dout_valid, 1'b1);
    check(tag, s_dout, exp);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dy_a    = pack4(64, -64, 127, -128);
    dx_pass = pack4(64, -64, 127, -128);
    dx_neg  = pack4(6, -7, 12, -13);

    rst = 1'b1;
    mask = '0; mask_valid = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    s_mask = '0; s_mask_valid = 1'b0; s_din = '0; s_din_valid = 1'b0; s_dout_ready = 1'b1;

    // Reset state, readies forced low
    step();
    mask_valid = 1'b1; din_valid = 1'b1; din = dy_a;
    #1;
    check("rst mask_ready", mask_ready, 1'b0);
    check("rst din_ready", din_ready, 1'b0);
    check("rst out_valid", dout_valid, 1'b0);
    check("rst out_data", dout, 32'h0);
    mask_valid = 1'b0; din_valid = 1'b0;
    step();
    rst = 1'b0;

    // Pass-through; a mask is not visible in the cycle it is pushed
    mask = 4'b0000; mask_valid = 1'b1; din = dy_a; din_valid = 1'b1;
    #1;
    check("no bypass din_ready", din_ready, 1'b0);
    check("empty mask_ready", mask_ready, 1'b1);
    step();
    mask_valid = 1'b0;
    #1;
    check("mask visible din_ready", din_ready, 1'b1);
    check("no output before fire", dout_valid, 1'b0);
    step();
    din_valid = 1'b0;
    check("pass valid", dout_valid, 1'b1);
    check("pass data", dout, dx_pass);
    step();
    check("valid clears", dout_valid, 1'b0);

    // Negative scaling
    push_mask(4'b1111);
    din = dy_a; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check("neg valid", dout_valid, 1'b1);
    check("neg data", dout, dx_neg);
    step();

    // Fraction widening with saturation
    sat_beat("sat pass", 4'b0000, pack4(127, -128, 1, -1), pack4(127, -128, 4, -4));
    sat_beat("sat neg", 4'b1111, dy_a, pack4(24, -28, 48, -52));

    // FIFO fill to full, then drain in order at full rate
    for (int k = 1; k <= 8; k++) begin
      mask = 4'(k); mask_valid = 1'b1;
      #1;
      check($sformatf("fill ready %0d", k), mask_ready, 1'b1);
      step();
    end
    mask = 4'hF;
    #1;
    check("full mask_ready", mask_ready, 1'b0);
    step();
    mask_valid = 1'b0;
    din = dy_a; din_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("order valid %0d", k), dout_valid, 1'b1);
      check($sformatf("order data %0d", k), dout, {32'h0, mix(4'(k))});
      if (k == 1) check("ready after pop", mask_ready, 1'b1);
    end
    check("empty din_ready", din_ready, 1'b0);
    step();
    check("no output when empty", dout_valid, 1'b0);
    din_valid = 1'b0;

    // Backpressure: held output stays stable, then drains 1 beat/cycle
    dout_ready = 1'b0;
    push_mask(4'b0101);
    push_mask(4'b1010);
    push_mask(4'b0011);
    din = dy_a; din_valid = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp valid %0d", c), dout_valid, 1'b1);
      check($sformatf("bp data %0d", c), dout, {32'h0, mix(4'b0101)});
      check($sformatf("bp din_ready %0d", c), din_ready, 1'b0);
      step();
    end
    dout_ready = 1'b1;
    #1;
    check("release din_ready", din_ready, 1'b1);
    step();
    check("drain 2 valid", dout_valid, 1'b1);
    check("drain 2 data", dout, {32'h0, mix(4'b1010)});
    step();
    check("drain 3 valid", dout_valid, 1'b1);
    check("drain 3 data", dout, {32'h0, mix(4'b0011)});
    din_valid = 1'b0;
    step();
    check("drained", dout_valid, 1'b0);

    // Mid-stream reset with 3 masks queued and an output beat held
    dout_ready = 1'b0;
    push_mask(4'b0001);
    push_mask(4'b0010);
    push_mask(4'b0100);
    push_mask(4'b1000);
    din_valid = 1'b1;
    step();
    check("pre-reset held", dout_valid, 1'b1);
    rst = 1'b1; mask_valid = 1'b1;
    #1;
    check("midrst mask_ready", mask_ready, 1'b0);
    check("midrst din_ready", din_ready, 1'b0);
    step();
    check("midrst out_valid", dout_valid, 1'b0);
    check("midrst out_data", dout, 32'h0);
    mask_valid = 1'b0; rst = 1'b0; dout_ready = 1'b1;
    #1;
    check("post-rst fifo empty", din_ready, 1'b0);
    check("post-rst mask_ready", mask_ready, 1'b1);
    step();
    check("post-rst no output", dout_valid, 1'b0);
    push_mask(4'b1111);
    step();
    din_valid = 1'b0;
    check("post-rst valid", dout_valid, 1'b1);
    check("post-rst data", dout, dx_neg);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
